// File: rtl/typing_sequence_checker.sv
// Keystroke judge for the speed-typing game: filters PS/2 bytes, scores make codes, runs the level countdown.
// Optional: define TYPER_STRICT_MODE_EN to end the level with fail on the first wrong make code.
module typing_sequence_checker #(
  parameter  int MAX_CHARS      = 12,
  parameter  int CNT_W          = 8,
  parameter  int TICKS_PER_UNIT = 50_000_000,
  localparam int IDX_W          = $clog2(MAX_CHARS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IDX_W-1:0]       num_char,
  input  logic [8*MAX_CHARS-1:0] sequence_,
  input  logic [7:0]             time_limit,
  input  logic                   key_valid,
  input  logic [7:0]             key_data,
  output logic                   busy,
  output logic                   pass,
  output logic                   fail,
  output logic [IDX_W-1:0]       char_index,
  output logic [CNT_W-1:0]       correct_count,
  output logic [CNT_W-1:0]       total_count,
  output logic [7:0]             time_left
);
  localparam int PS_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state, state_n;
  logic [IDX_W-1:0] len, len_n, clamp_len, idx_n;
  logic [CNT_W-1:0] cc_n, tc_n;
  logic [7:0]       tl_n;
  logic [PS_W-1:0]  ps, ps_n;
  logic             ext, ext_n, brk, brk_n;
  logic             pass_n, fail_n, busy_n;
  logic             active, match;

  assign clamp_len = (num_char > IDX_W'(MAX_CHARS)) ? IDX_W'(MAX_CHARS) : num_char;
  assign active    = (state == ARMED) || (state == RUN);
  assign match     = (key_data == sequence_[{char_index, 3'b000} +: 8]);

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = char_index;
    cc_n    = correct_count;
    tc_n    = total_count;
    tl_n    = time_left;
    ps_n    = ps;
    ext_n   = ext;
    brk_n   = brk;
    pass_n  = 1'b0;
    fail_n  = 1'b0;
    if (start) begin
      // Same-cycle key bytes are dropped so a restart always begins clean.
      len_n = clamp_len;
      idx_n = '0;
      cc_n  = '0;
      tc_n  = '0;
      tl_n  = time_limit;
      ps_n  = '0;
      ext_n = 1'b0;
      brk_n = 1'b0;
      if (clamp_len == '0) begin
        state_n = DONE;
        pass_n  = 1'b1;
      end else begin
        state_n = ARMED;
      end
    end else if (active) begin
      if (state == RUN) begin
        if (time_left == 8'd0) begin
          fail_n  = 1'b1;
          state_n = DONE;
        end else if (ps == PS_W'(TICKS_PER_UNIT - 1)) begin
          ps_n = '0;
          tl_n = time_left - 8'd1;
          if (time_left == 8'd1) begin
            fail_n  = 1'b1;
            state_n = DONE;
          end
        end else begin
          ps_n = ps + 1'b1;
        end
      end
      if (key_valid) begin
        if (brk) begin
          brk_n = 1'b0;
          ext_n = 1'b0;
        end else if (key_data == 8'hE0) begin
          ext_n = 1'b1;
        end else if (key_data == 8'hF0) begin
          brk_n = 1'b1;
        end else begin
          ext_n = 1'b0;
          tc_n  = (&total_count) ? total_count : total_count + 1'b1;
          if (state == ARMED) state_n = RUN;
          if (match) begin
            cc_n  = (&correct_count) ? correct_count : correct_count + 1'b1;
            idx_n = char_index + 1'b1;
            // Completing the level outranks a timeout on the same edge.
            if (idx_n == len) begin
              pass_n  = 1'b1;
              fail_n  = 1'b0;
              state_n = DONE;
            end
          end else begin
`ifdef TYPER_STRICT_MODE_EN
            fail_n  = 1'b1;
            state_n = DONE;
`endif
          end
        end
      end
    end
    busy_n = (state_n == ARMED) || (state_n == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      char_index    <= '0;
      correct_count <= '0;
      total_count   <= '0;
      time_left     <= '0;
      ps            <= '0;
      ext           <= 1'b0;
      brk           <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      len           <= len_n;
      char_index    <= idx_n;
      correct_count <= cc_n;
      total_count   <= tc_n;
      time_left     <= tl_n;
      ps            <= ps_n;
      ext           <= ext_n;
      brk           <= brk_n;
      pass          <= pass_n;
      fail          <= fail_n;
      busy          <= busy_n;
    end
  end
endmodule

// File: tb/tb_typing_sequence_checker.sv
// Scoreboard bench for typing_sequence_checker with a 4-tick countdown unit.
module tb_typing_sequence_checker;
  localparam int MAX_CHARS = 12;
  localparam int IDX_W     = $clog2(MAX_CHARS + 1);

  logic                   clk = 1'b0;
  logic                   reset, start, key_valid;
  logic [IDX_W-1:0]       num_char;
  logic [8*MAX_CHARS-1:0] seq;
  logic [7:0]             time_limit, key_data;
  logic                   busy, pass, fail;
  logic [IDX_W-1:0]       char_index;
  logic [7:0]             correct_count, total_count, time_left;

  typing_sequence_checker #(.MAX_CHARS(MAX_CHARS), .CNT_W(8), .TICKS_PER_UNIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_char(num_char), .sequence_(seq),
    .time_limit(time_limit), .key_valid(key_valid), .key_data(key_data), .busy(busy),
    .pass(pass), .fail(fail), .char_index(char_index), .correct_count(correct_count),
    .total_count(total_count), .time_left(time_left)
  );

  always #5 clk = ~clk;

  typedef struct { logic p; int c; int t; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Each pass/fail pulse is matched against the oldest expected level outcome.
  always @(negedge clk) begin
    if (!reset && (pass || fail)) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {30'd0, pass, fail}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_pass", pass, e.p);
        chk("sb_fail", fail, !e.p);
        chk("sb_correct", correct_count, e.c);
        chk("sb_total", total_count, e.t);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic send(input logic [7:0] b);
    key_valid = 1'b1; key_data = b; tick(); key_valid = 1'b0;
  endtask
  task automatic go(input logic [IDX_W-1:0] n, input logic [7:0] tl);
    num_char = n; time_limit = tl; start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic push(input logic p, input int c, input int t);
    exp_t x; x.p = p; x.c = c; x.t = t; exp_q.push_back(x);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = 8'h00;
    num_char = '0; time_limit = 8'd0; seq = '0;
    seq[23:0] = 24'h21321C;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_pf", {pass, fail}, 0);
    chk("rst_cnts", {correct_count, total_count, time_left}, 0);
    chk("rst_idx", char_index, 0);
    @(negedge clk); reset = 1'b0;
    tick();

    // Basic level with break codes interleaved.
    go(4'd3, 8'd10);
    chk("arm_busy", busy, 1);
    chk("arm_tl", time_left, 10);
    push(1'b1, 3, 3);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32); send(8'hF0); send(8'h32); send(8'h21);
    chk("pass_latency", pass, 1);
    chk("pass_busy", busy, 0);
    drain("s1_drain");
    chk("s1_idx", char_index, 3);
    chk("s1_tl_pos", time_left > 0, 1);
    repeat (3) tick();

    // Wrong key mid-level.
    go(4'd3, 8'd10);
`ifdef TYPER_STRICT_MODE_EN
    push(1'b0, 1, 2);
`else
    push(1'b1, 3, 4);
`endif
    send(8'h1C); send(8'h2B); send(8'h32); send(8'h21);
    drain("s2_drain");

    // Timeout: frozen while armed, then 8 cycles of RUN for two units.
    go(4'd3, 8'd2);
    repeat (10) tick();
    chk("armed_frozen", time_left, 2);
    push(1'b0, 1, 1);
    send(8'h1C);
    n = 0;
    while (!fail && n < 30) begin tick(); n++; end
    chk("timeout_cycles", n, 8);
    chk("timeout_tl", time_left, 0);
    drain("s3_drain");

    // Zero time limit fails on the first RUN cycle.
    go(4'd3, 8'd0);
    push(1'b0, 1, 1);
    send(8'h1C);
    tick();
    chk("tl0_fail", fail, 1);
    drain("s3b_drain");

    // Start with a simultaneous key, extended prefix, break discard, restart mid-RUN.
    num_char = 4'd3; time_limit = 8'd10; start = 1'b1; key_valid = 1'b1; key_data = 8'h1C;
    tick(); start = 1'b0; key_valid = 1'b0;
    chk("start_key_ignored", total_count, 0);
    send(8'hE0); send(8'h1C);
    chk("ext_total", total_count, 1);
    chk("ext_correct", correct_count, 1);
    send(8'hF0); send(8'h32);
    chk("brk_total", total_count, 1);
    chk("brk_idx", char_index, 1);
    push(1'b1, 0, 0);
    go(4'd0, 8'd10);
    chk("restart_pass", pass, 1);
    chk("restart_idx", char_index, 0);
    drain("s4_drain");

    // Length clamp to MAX_CHARS.
    for (int i = 0; i < MAX_CHARS; i++) seq[8*i +: 8] = 8'(8'h15 + i);
    go(4'd15, 8'd50);
    push(1'b1, 12, 12);
    for (int i = 0; i < MAX_CHARS; i++) send(8'(8'h15 + i));
    drain("s5_drain");
    chk("clamp_idx", char_index, 12);

    // Asynchronous reset mid-RUN.
    seq[23:0] = 24'h21321C;
    go(4'd3, 8'd10);
    send(8'h1C);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnts", {correct_count, total_count, time_left}, 0);
    chk("arst_idx", char_index, 0);
    @(negedge clk); reset = 1'b0;
    send(8'h1C); send(8'h32);
    chk("post_rst_total", total_count, 0);
    chk("post_rst_busy", busy, 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/typing_sequence_checker.md
# typing_sequence_checker

Parametrised keystroke judge for the speed-typing game. It sits between the PS/2 receiver and the game FSM/VGA drawing logic. It takes a loaded level (flat character vector plus length), filters PS/2 break and extended-prefix bytes, and compares each make code against the expected character. It keeps correct and total keystroke counts, runs a per-level countdown, and reports one-cycle pass/fail pulses.

## Interface
- `MAX_CHARS`, 12, maximum characters per level (≥1).
- `CNT_W`, 8, width of the keystroke counters.
- `TICKS_PER_UNIT`, 50_000_000, clk cycles per countdown unit (1 s at 50 MHz).
- `IDX_W`, $clog2(MAX_CHARS+1), width of length/index fields (derived; do not override).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `num_char`/`time_limit` and begins a level.
- `num_char`  in  IDX_W  characters in this level; values > MAX_CHARS clamp to MAX_CHARS.
- `sequence_`  in  8*MAX_CHARS  expected make codes; char i at [8i+7:8i]; held stable while busy.
- `time_limit`  in  8  countdown units allowed for the level.
- `key_valid`  in  1  one-cycle strobe from PS/2 receiver.
- `key_data`  in  8  received byte, valid with `key_valid`.
- `busy`  out  1  level in progress (ARMED or RUN).
- `pass`  out  1  one-cycle pulse, level completed.
- `fail`  out  1  one-cycle pulse, timeout (or wrong key, see Configuration).
- `char_index`  out  IDX_W  index of the next expected character.
- `correct_count`  out  CNT_W  correct make codes this level.
- `total_count`  out  CNT_W  all make codes this level.
- `time_left`  out  8  remaining countdown units.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE: waits for `start`.
- `start`: clears both counters, `char_index` and the prescaler; loads `time_left`=`time_limit`; goes to ARMED. If the clamped length is 0, it goes to DONE and pulses `pass` instead.
- ARMED: timer is frozen. The first make code enters RUN and is judged like any other.
- Byte filter, active in ARMED and RUN:
  - 0xE0 sets an ext flag and is otherwise ignored.
  - 0xF0 sets a brk flag.
  - The byte after 0xF0 is discarded; both flags clear.
  - Any other byte is a make code; the ext flag clears on it.
- Make code handling: `total_count`+1.
  - If it equals `sequence_[8*char_index+:8]`: `correct_count`+1 and `char_index`+1.
  - Otherwise: index unchanged.
- Pass: when `char_index` reaches the latched length, pulse `pass` and go to DONE.
- RUN timer: the prescaler counts 0..TICKS_PER_UNIT-1; on wrap, `time_left`−1. When `time_left` reaches 0, pulse `fail` and go to DONE.
- DONE: counters and `time_left` hold their values for display. `start` begins a new level.
- `start` in any state, including mid-level, restarts the level. Bytes arriving in the same cycle are ignored.
- Counters saturate at all-ones.
- `time_limit`=0: fail fires on the first cycle in RUN.
- Reset: state IDLE, all outputs 0, flags cleared.

## Timing
- All outputs are registered.
- `key_valid` at edge N updates counters and `char_index` at edge N+1. `pass` is high for the cycle after edge N+1.
- Timeout: `fail` is high for exactly one cycle after the edge where `time_left` becomes 0.
- Final correct key and timeout on the same edge: `pass` wins and `fail` is suppressed.
- `busy` deasserts on the same edge that `pass`/`fail` asserts.
- Back-to-back `key_valid` on consecutive cycles is accepted.

## Configuration
- `TYPER_STRICT_MODE_EN` defined: a mismatched make code in RUN or ARMED pulses `fail` and goes to DONE. Counts still update for that key. Pass has priority over fail when both occur on the same edge.
- Not defined: mismatches only advance `total_count`; fail comes from timeout alone.

## Test plan
- TICKS_PER_UNIT=4, start num_char=3, seq {0x1C,0x32,0x21}, time_limit=10. Keys 1C,F0,1C,32,F0,32,21 -> `pass` once; correct=3, total=3, time_left>0.
- Same level, keys 1C,2B,32,21 (non-strict) -> pass; correct=3, total=4. With macro -> `fail` after 2B; correct=1, total=2.
- time_limit=2, one correct key then idle -> `fail` exactly 8 cycles after entering RUN; time_left=0. No decrement occurs while ARMED.
- Keys E0,1C -> counted as make 0x1C. Keys F0,1C -> discarded; total unchanged.
- `start` mid-RUN with num_char=0 -> counters clear and `pass` on the next cycle. num_char=15 with MAX_CHARS=12 clamps to 12.
- Assert `reset` asynchronously mid-RUN -> all outputs 0 immediately. Keys after release are ignored until `start`.
